// File: rtl/axi_uram_pkg.sv
// axi_uram_pkg -- shared types and constants for the axi_uram controller.
//   wstate_e   : write-channel FSM states (IDLE -> DATA -> RESP)
//   rstate_e   : read-channel FSM states (IDLE -> BURST)
//   RBUF_DEPTH : depth of the read-data output FIFO
//   credit_ok  : read-issue credit check shared by the read path
package axi_uram_pkg;

  localparam int RBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rstate_e;

  // A RAM read may be issued only if the slot it will occupy is guaranteed
  // to exist when its data returns: reads in flight plus entries still held
  // after this cycle's pop must stay below the FIFO depth.
  function automatic logic credit_ok(input logic       inflight,
                                     input logic [1:0] count,
                                     input logic       pop);
    logic [2:0] used;
    used = {2'b00, inflight} + {1'b0, count} - {2'b00, pop};
    return (used < 3'(RBUF_DEPTH));
  endfunction

endpackage

// File: rtl/axi_uram_rbuf.sv
// axi_uram_rbuf -- 2-entry output FIFO for read beats.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write one entry (ignored when full)
//   pop      : remove the head entry (ignored when empty)
//   dout     : head entry (zero after reset)
//   count    : number of valid entries (0..2)
module axi_uram_rbuf
  import axi_uram_pkg::*;
#(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [RBUF_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push & (count_r != 2'(RBUF_DEPTH));
  assign pop_s  = pop & (count_r != 2'd0);
  assign dout   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RBUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_uram_ctrl.sv
// axi_uram_ctrl -- AXI4 slave front end for a dual-port on-chip RAM.
//   Writes use RAM port A (addra/dina/wea), reads use port B (addrb/doutb),
//   so one write burst and one read burst can progress concurrently.
//   aclk/arst           : clock, asynchronous active-high reset
//   aw*/w*/b*           : AXI write address, data and response channels
//   ar*/r*              : AXI read address and data channels
//   addra/dina/wea      : RAM port A write interface
//   addrb/doutb         : RAM port B read interface (1-cycle read latency)
// Every burst is treated as INCR with one full word per beat; word
// addresses wrap modulo the RAM depth.
module axi_uram_ctrl
  import axi_uram_pkg::*;
#(
  parameter  int DATA_WIDTH = 128,
  parameter  int ADDR_WIDTH = 12,
  parameter  int ID_WIDTH   = 8,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int BYTE_BITS  = $clog2(BYTES)
) (
  input  logic                            aclk,
  input  logic                            arst,
  input  logic [ID_WIDTH-1:0]             awid,
  input  logic [ADDR_WIDTH+BYTE_BITS-1:0] awaddr,
  input  logic [7:0]                      awlen,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [BYTES-1:0]                wstrb,
  input  logic                            wlast,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [ID_WIDTH-1:0]             bid,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [ID_WIDTH-1:0]             arid,
  input  logic [ADDR_WIDTH+BYTE_BITS-1:0] araddr,
  input  logic [7:0]                      arlen,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [ID_WIDTH-1:0]             rid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rlast,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [ADDR_WIDTH-1:0]           addra,
  output logic [DATA_WIDTH-1:0]           dina,
  output logic [BYTES-1:0]                wea,
  output logic [ADDR_WIDTH-1:0]           addrb,
  input  logic [DATA_WIDTH-1:0]           doutb
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------- write
  wstate_e               wstate_r;
  wstate_e               wstate_s;
  logic [ID_WIDTH-1:0]   bid_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic                  aw_hs_s;
  logic                  w_hs_s;

  assign awready = (wstate_r == W_IDLE);
  assign wready  = (wstate_r == W_DATA);
  assign bvalid  = (wstate_r == W_RESP);
  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;
  assign bid     = bid_r;
  assign addra   = waddr_r;
  assign dina    = wdata;
  // The RAM write happens in the same cycle as the W handshake.
  assign wea     = w_hs_s ? wstrb : {BYTES{1'b0}};

  // Write FSM next-state logic.
  always_comb begin
    wstate_s = wstate_r;
    case (wstate_r)
      W_IDLE: begin
        if (aw_hs_s) wstate_s = W_DATA;
        else         wstate_s = W_IDLE;
      end
      W_DATA: begin
        if (w_hs_s && wlast) wstate_s = W_RESP;
        else                 wstate_s = W_DATA;
      end
      W_RESP: begin
        if (bready) wstate_s = W_IDLE;
        else        wstate_s = W_RESP;
      end
      default: wstate_s = W_IDLE;
    endcase
  end

  // Write FSM state, response ID and port A word address.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wstate_r <= W_IDLE;
      bid_r    <= '0;
      waddr_r  <= '0;
    end else begin
      wstate_r <= wstate_s;
      if (aw_hs_s) begin
        bid_r   <= awid;
        waddr_r <= awaddr[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS];
      end else if (w_hs_s) begin
        waddr_r <= waddr_r + ADDR_ONE;
      end
    end
  end

  // ----------------------------------------------------------------- read
  rstate_e               rstate_r;
  rstate_e               rstate_s;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic [8:0]            issue_left_r;   // RAM reads still to be issued
  logic                  pend_r;         // a RAM read returns data this cycle
  logic                  pend_last_r;    // ... and it is the final beat
  logic                  ar_hs_s;
  logic                  issue_s;
  logic                  pop_s;
  logic [1:0]            fifo_count_s;
  logic [DATA_WIDTH:0]   fifo_dout_s;

  assign arready = (rstate_r == R_IDLE);
  assign ar_hs_s = arvalid & arready;
  assign rvalid  = (fifo_count_s != 2'd0);
  assign pop_s   = rvalid & rready;
  assign rdata   = fifo_dout_s[DATA_WIDTH-1:0];
  assign rlast   = rvalid & fifo_dout_s[DATA_WIDTH];
  assign rid     = rid_r;
  assign addrb   = raddr_r;

  // Read issue decision: one RAM read per cycle while credit allows.
  always_comb begin
    issue_s = 1'b0;
    if ((rstate_r == R_BURST) && (issue_left_r != 9'd0) &&
        credit_ok(pend_r, fifo_count_s, pop_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Read FSM next-state logic; the burst ends when its last beat leaves.
  always_comb begin
    rstate_s = rstate_r;
    case (rstate_r)
      R_IDLE: begin
        if (ar_hs_s) rstate_s = R_BURST;
        else         rstate_s = R_IDLE;
      end
      R_BURST: begin
        if (pop_s && rlast) rstate_s = R_IDLE;
        else                rstate_s = R_BURST;
      end
      default: rstate_s = R_IDLE;
    endcase
  end

  // Read FSM state, burst bookkeeping and the RAM-latency pipeline stage.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rstate_r     <= R_IDLE;
      rid_r        <= '0;
      raddr_r      <= '0;
      issue_left_r <= 9'd0;
      pend_r       <= 1'b0;
      pend_last_r  <= 1'b0;
    end else begin
      rstate_r    <= rstate_s;
      pend_r      <= issue_s;
      pend_last_r <= issue_s & (issue_left_r == 9'd1);
      if (ar_hs_s) begin
        rid_r        <= arid;
        raddr_r      <= araddr[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS];
        issue_left_r <= {1'b0, arlen} + 9'd1;
      end else if (issue_s) begin
        raddr_r      <= raddr_r + ADDR_ONE;
        issue_left_r <= issue_left_r - 9'd1;
      end
    end
  end

  // Returned RAM words queue here with their last-beat flag.
  axi_uram_rbuf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_rbuf (
    .clk  (aclk),
    .rst  (arst),
    .push (pend_r),
    .din  ({pend_last_r, doutb}),
    .pop  (pop_s),
    .dout (fifo_dout_s),
    .count(fifo_count_s)
  );

endmodule
